clk_div_detector: RTL and testbench

- Receive-side counterpart of the selectable clock divider.
- Observes a divided clock, generated synchronously from the same clk, and measures its period in clk cycles.
- Decodes the period back into the 2-bit divide-select code (/2, /4, /8, /16).
- Reports lock once the ratio has been stable for LOCK_COUNT consecutive periods, with error flagging on invalid periods, ratio changes and loss of toggling.

---
 rtl/clk_div_detector.sv | 145 ++++++++++++++
 tb/tb_clk_div_detector.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_detector.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_detector
// Brief    : Measures the rising-edge spacing of a synchronous divided clock,
//            decodes it to a /2../16 select code and reports lock / errors.
// Revision : 1.0
// ============================================================================
module clk_div_detector #(
   parameter int COUNT_W    = 8,
   parameter int LOCK_COUNT = 3,
   parameter int TIMEOUT    = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               div_in,
   output logic [1:0]         sel_out,
   output logic               locked,
   output logic               err,
   output logic [COUNT_W-1:0] period_out
);

   localparam logic [COUNT_W-1:0] c_TIMEOUT = COUNT_W'(TIMEOUT);
   localparam logic [3:0]         c_LOCK    = 4'(LOCK_COUNT);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_MEASURE = 2'd1,
      S_LOCKED  = 2'd2
   } state_t;

   state_t             r_state;
   logic               r_div_q;
   logic [COUNT_W-1:0] r_cnt;
   logic [3:0]         r_match;
   logic [1:0]         r_cand;
   logic [1:0]         r_sel;
   logic               r_locked;
   logic               r_err;
   logic [COUNT_W-1:0] r_period;

   logic               w_rise;
   logic               w_timeout;
   logic               w_valid;
   logic [1:0]         w_code;
   logic [3:0]         w_next_match;

   assign w_rise    = div_in & ~r_div_q;
   assign w_timeout = (r_cnt == c_TIMEOUT);

   // The counter value at a rise is the period; only exact powers map to a code.
   always_comb begin
      w_valid = 1'b1;
      w_code  = 2'b00;
      case (r_cnt)
         COUNT_W'(2):  w_code = 2'b00;
         COUNT_W'(4):  w_code = 2'b01;
         COUNT_W'(8):  w_code = 2'b10;
         COUNT_W'(16): w_code = 2'b11;
         default:      w_valid = 1'b0;
      endcase
   end

   assign w_next_match = ((w_code == r_cand) && (r_match != 4'd0)) ? (r_match + 4'd1) : 4'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_div_q  <= 1'b0;
         r_cnt    <= '0;
         r_match  <= 4'd0;
         r_cand   <= 2'b00;
         r_sel    <= 2'b00;
         r_locked <= 1'b0;
         r_err    <= 1'b0;
         r_period <= '0;
      end else begin
         r_div_q <= div_in;
         r_err   <= 1'b0;

         if (w_rise) begin
            r_cnt <= COUNT_W'(1);
         end else if (!w_timeout) begin
            r_cnt <= r_cnt + COUNT_W'(1);
         end

         case (r_state)
            S_IDLE: begin
               if (w_rise) begin
                  r_state <= S_MEASURE;
                  r_match <= 4'd0;
               end
            end

            S_MEASURE: begin
               if (w_rise) begin
                  r_period <= r_cnt;
                  if (!w_valid) begin
                     r_match <= 4'd0;
                     r_err   <= 1'b1;
                  end else begin
                     r_cand  <= w_code;
                     r_match <= w_next_match;
                     if (w_next_match == c_LOCK) begin
                        r_state  <= S_LOCKED;
                        r_locked <= 1'b1;
                        r_sel    <= w_code;
                     end
                  end
               end else if (w_timeout) begin
                  r_state <= S_IDLE;
                  r_match <= 4'd0;
                  r_err   <= 1'b1;
               end
            end

            S_LOCKED: begin
               if (w_rise) begin
                  r_period <= r_cnt;
                  if (!w_valid || (w_code != r_sel)) begin
                     r_state  <= S_MEASURE;
                     r_locked <= 1'b0;
                     r_err    <= 1'b1;
                     r_cand   <= w_valid ? w_code : r_cand;
                     r_match  <= w_valid ? 4'd1 : 4'd0;
                  end
               end else if (w_timeout) begin
                  r_state  <= S_IDLE;
                  r_locked <= 1'b0;
                  r_match  <= 4'd0;
                  r_err    <= 1'b1;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign sel_out    = r_sel;
   assign locked     = r_locked;
   assign err        = r_err;
   assign period_out = r_period;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_detector
// Brief    : Directed scenarios plus randomized periods against an event model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_clk_div_detector;

   localparam int COUNT_W    = 8;
   localparam int LOCK_COUNT = 3;
   localparam int TIMEOUT    = 64;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               div_in = 1'b0;
   logic [1:0]         sel_out;
   logic               locked;
   logic               err;
   logic [COUNT_W-1:0] period_out;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   clk_div_detector #(
      .COUNT_W    (COUNT_W),
      .LOCK_COUNT (LOCK_COUNT),
      .TIMEOUT    (TIMEOUT)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .div_in     (div_in),
      .sel_out    (sel_out),
      .locked     (locked),
      .err        (err),
      .period_out (period_out)
   );

   // Event model: remembers when the last rise happened and how many
   // consecutive equal valid periods have been seen.
   bit         m_prev, m_seen, m_locked, m_err;
   logic [1:0] m_sel, m_code;
   int         m_per, m_run, m_last, cyc;

   task automatic clk_step(input logic d, input logic r);
      int         p;
      bit         rise, valid;
      logic [1:0] code;
      div_in = d;
      rst    = r;
      @(posedge clk);
      if (r) begin
         m_prev = 0; m_seen = 0; m_locked = 0; m_err = 0;
         m_sel = 0; m_code = 0; m_per = 0; m_run = 0;
      end else begin
         rise   = d && !m_prev;
         m_prev = d;
         m_err  = 0;
         if (rise) begin
            if (m_seen) begin
               p     = (cyc - m_last > TIMEOUT) ? TIMEOUT : cyc - m_last;
               valid = (p == 2) || (p == 4) || (p == 8) || (p == 16);
               code  = valid ? 2'($clog2(p) - 1) : 2'b00;
               m_per = p;
               if (m_locked) begin
                  if (!(valid && code == m_sel)) begin
                     m_locked = 0;
                     m_err    = 1;
                     if (valid) begin m_code = code; m_run = 1; end
                     else m_run = 0;
                  end
               end else if (!valid) begin
                  m_run = 0;
                  m_err = 1;
               end else begin
                  if (m_run > 0 && code == m_code) m_run++;
                  else begin m_run = 1; m_code = code; end
                  if (m_run == LOCK_COUNT) begin m_locked = 1; m_sel = m_code; end
               end
            end else begin
               m_seen = 1;
               m_run  = 0;
            end
            m_last = cyc;
         end else if (m_seen && (cyc - m_last == TIMEOUT)) begin
            m_seen = 0; m_locked = 0; m_run = 0; m_err = 1;
         end
      end
      cyc++;
      #1;
   endtask

   // One period of h high + l low cycles; snapshots are taken right after the rise.
   task automatic do_period(input int h, input int l, output logic o_lk, output logic o_er,
                            output logic [1:0] o_sl, output logic [COUNT_W-1:0] o_pr,
                            output logic o_er2);
      for (int i = 0; i < h + l; i++) begin
         clk_step((i < h) ? 1'b1 : 1'b0, 1'b0);
         if (i == 0) begin o_lk = locked; o_er = err; o_sl = sel_out; o_pr = period_out; end
         if (i == 1) o_er2 = err;
      end
   endtask

   task automatic test_reset;
      clk_step(1'b0, 1'b1);
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got %0b want 0", locked); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %0b want 0", err); end
      total++; if (sel_out !== 2'b00) begin bad++; $display("FAIL reset_sel: got %0d want 0", sel_out); end
      total++; if (period_out !== '0) begin bad++; $display("FAIL reset_period: got %0d want 0", period_out); end
   endtask

   task automatic test_div2;
      logic lk, er, er2; logic [1:0] sl; logic [COUNT_W-1:0] pr;
      int nerr = 0;
      clk_step(1'b0, 1'b1);
      for (int k = 1; k <= 6; k++) begin
         do_period(1, 1, lk, er, sl, pr, er2);
         if (er || er2) nerr++;
         if (k == 3) begin total++; if (lk !== 1'b0) begin bad++; $display("FAIL div2_early: locked=%0b want 0", lk); end end
         if (k == 4) begin
            total++; if (lk !== 1'b1) begin bad++; $display("FAIL div2_lock: locked=%0b want 1", lk); end
            total++; if (sl !== 2'b00) begin bad++; $display("FAIL div2_sel: got %0d want 0", sl); end
            total++; if (pr !== 8'd2) begin bad++; $display("FAIL div2_period: got %0d want 2", pr); end
         end
      end
      total++; if (nerr !== 0) begin bad++; $display("FAIL div2_err: pulses=%0d want 0", nerr); end
   endtask

   task automatic test_div16;
      logic lk, er, er2; logic [1:0] sl; logic [COUNT_W-1:0] pr;
      clk_step(1'b0, 1'b1);
      for (int k = 1; k <= 5; k++) begin
         do_period(8, 8, lk, er, sl, pr, er2);
         if (k == 3) begin total++; if (lk !== 1'b0) begin bad++; $display("FAIL div16_early: locked=%0b want 0", lk); end end
         if (k == 4) begin
            total++; if (lk !== 1'b1) begin bad++; $display("FAIL div16_lock: locked=%0b want 1", lk); end
            total++; if (sl !== 2'b11) begin bad++; $display("FAIL div16_sel: got %0d want 3", sl); end
            total++; if (pr !== 8'd16) begin bad++; $display("FAIL div16_period: got %0d want 16", pr); end
         end
      end
   endtask

   task automatic test_switch;
      logic lk, er, er2; logic [1:0] sl; logic [COUNT_W-1:0] pr;
      clk_step(1'b0, 1'b1);
      for (int k = 1; k <= 5; k++) do_period(2, 2, lk, er, sl, pr, er2);
      total++; if (lk !== 1'b1 || sl !== 2'b01) begin bad++; $display("FAIL sw_lock4: locked=%0b sel=%0d want 1/1", lk, sl); end
      do_period(4, 4, lk, er, sl, pr, er2);
      total++; if (lk !== 1'b1 || er !== 1'b0) begin bad++; $display("FAIL sw_trans: locked=%0b err=%0b want 1/0", lk, er); end
      do_period(4, 4, lk, er, sl, pr, er2);
      total++; if (lk !== 1'b0) begin bad++; $display("FAIL sw_unlock: locked=%0b want 0", lk); end
      total++; if (er !== 1'b1 || er2 !== 1'b0) begin bad++; $display("FAIL sw_errpulse: err=%0b,%0b want 1,0", er, er2); end
      do_period(4, 4, lk, er, sl, pr, er2);
      total++; if (lk !== 1'b0 || er !== 1'b0) begin bad++; $display("FAIL sw_mid: locked=%0b err=%0b want 0/0", lk, er); end
      do_period(4, 4, lk, er, sl, pr, er2);
      total++; if (lk !== 1'b1) begin bad++; $display("FAIL sw_relock: locked=%0b want 1", lk); end
      total++; if (sl !== 2'b10 || pr !== 8'd8) begin bad++; $display("FAIL sw_sel: sel=%0d period=%0d want 2/8", sl, pr); end
   endtask

   task automatic test_timeout;
      logic lk, er, er2; logic [1:0] sl; logic [COUNT_W-1:0] pr;
      int k = 1; int nerr = 0; bit seen = 0;
      clk_step(1'b0, 1'b1);
      for (int n = 1; n <= 5; n++) do_period(1, 1, lk, er, sl, pr, er2);
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL to_prelock: locked=%0b want 1", locked); end
      while (!seen && k < 200) begin
         clk_step(1'b0, 1'b0);
         k++;
         if (err === 1'b1) seen = 1;
      end
      total++; if (!seen || k !== TIMEOUT) begin bad++; $display("FAIL to_delay: err after %0d cycles (seen=%0b) want %0d", k, seen, TIMEOUT); end
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL to_unlock: locked=%0b want 0", locked); end
      for (int n = 0; n < 80; n++) begin clk_step(1'b0, 1'b0); if (err) nerr++; end
      total++; if (nerr !== 0) begin bad++; $display("FAIL to_idle_err: pulses=%0d want 0", nerr); end
      for (int n = 1; n <= 4; n++) begin
         do_period(1, 1, lk, er, sl, pr, er2);
         if (n == 3) begin total++; if (lk !== 1'b0) begin bad++; $display("FAIL to_relock_early: locked=%0b want 0", lk); end end
      end
      total++; if (lk !== 1'b1 || sl !== 2'b00) begin bad++; $display("FAIL to_relock: locked=%0b sel=%0d want 1/0", lk, sl); end
   endtask

   task automatic test_period6;
      logic lk, er, er2; logic [1:0] sl; logic [COUNT_W-1:0] pr;
      clk_step(1'b0, 1'b1);
      do_period(3, 3, lk, er, sl, pr, er2);
      total++; if (er !== 1'b0) begin bad++; $display("FAIL p6_first: err=%0b want 0", er); end
      for (int k = 2; k <= 6; k++) begin
         do_period(3, 3, lk, er, sl, pr, er2);
         total++; if (er !== 1'b1 || er2 !== 1'b0) begin bad++; $display("FAIL p6_err: rise %0d err=%0b,%0b want 1,0", k, er, er2); end
         total++; if (lk !== 1'b0 || pr !== 8'd6) begin bad++; $display("FAIL p6_state: locked=%0b period=%0d want 0/6", lk, pr); end
      end
   endtask

   task automatic test_rst_mid;
      logic lk, er, er2; logic [1:0] sl; logic [COUNT_W-1:0] pr;
      clk_step(1'b0, 1'b1);
      for (int k = 1; k <= 3; k++) do_period(4, 4, lk, er, sl, pr, er2);
      clk_step(1'b1, 1'b1);
      total++; if (locked !== 1'b0 || err !== 1'b0 || sel_out !== 2'b00 || period_out !== '0) begin
         bad++; $display("FAIL rstmid_outs: locked=%0b err=%0b sel=%0d period=%0d want 0", locked, err, sel_out, period_out);
      end
      for (int k = 1; k <= 4; k++) begin
         do_period(4, 4, lk, er, sl, pr, er2);
         if (k == 3) begin total++; if (lk !== 1'b0) begin bad++; $display("FAIL rstmid_early: locked=%0b want 0", lk); end end
      end
      total++; if (lk !== 1'b1 || sl !== 2'b10) begin bad++; $display("FAIL rstmid_lock: locked=%0b sel=%0d want 1/2", lk, sl); end
   endtask

   task automatic test_random;
      int kind, p, reps, h;
      clk_step(1'b0, 1'b1);
      for (int n = 0; n < 150; n++) begin
         kind = $urandom_range(0, 9);
         if (kind <= 5)      p = 2 << $urandom_range(0, 3);
         else if (kind <= 7) p = $urandom_range(3, 20);
         else if (kind == 8) p = $urandom_range(60, 70);
         else                p = $urandom_range(2, 17);
         reps = $urandom_range(1, 6);
         for (int r = 0; r < reps; r++) begin
            h = $urandom_range(1, p - 1);
            for (int i = 0; i < p; i++) begin
               clk_step((i < h) ? 1'b1 : 1'b0, ($urandom_range(0, 999) == 0) ? 1'b1 : 1'b0);
               total++; if (locked !== m_locked) begin bad++; $display("FAIL rnd_locked: cyc=%0d got %0b want %0b", cyc, locked, m_locked); end
               total++; if (err !== m_err) begin bad++; $display("FAIL rnd_err: cyc=%0d got %0b want %0b", cyc, err, m_err); end
               total++; if (period_out !== COUNT_W'(m_per)) begin bad++; $display("FAIL rnd_period: cyc=%0d got %0d want %0d", cyc, period_out, m_per); end
               if (m_locked) begin
                  total++; if (sel_out !== m_sel) begin bad++; $display("FAIL rnd_sel: cyc=%0d got %0d want %0d", cyc, sel_out, m_sel); end
               end
            end
         end
      end
   endtask

   initial begin
      cyc = 0;
      test_reset();
      test_div2();
      test_div16();
      test_switch();
      test_timeout();
      test_period6();
      test_rst_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
